// File: rtl/div_unit_8bit.sv
// div_unit_8bit: sequential unsigned restoring divider.
// Produces one quotient bit per clock behind a start/busy/done handshake.
// A zero divisor skips the iteration and reports div_by_zero together with done.
// In that case the quotient is all-ones and the remainder is the dividend.
module div_unit_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_next;

    // The dividend register shifts left every iteration, and the new quotient bit
    // enters at its LSB. After WIDTH iterations it holds the quotient.
    logic [WIDTH:0]   part_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [CW-1:0]    cnt_q;
    logic             dbz_q;

    logic             accept;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             borrow;

    // Trial subtraction for the current iteration.
    always_comb begin
        shifted = {part_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, dvsr_q};
        borrow  = trial[WIDTH+1];
    end

    assign accept = (state == IDLE) && start;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state <= state_next;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        // NOTE: defaults come first so that no path leaves a variable unassigned,
        // which would otherwise infer a latch.
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            part_q <= '0;
            dvd_q  <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
            dbz_q  <= 1'b0;
        end else if (accept) begin
            dvsr_q <= divisor;
            if (divisor == '0) begin
                dvd_q  <= '1;
                part_q <= {1'b0, dividend};
                cnt_q  <= '0;
                dbz_q  <= 1'b1;
            end else begin
                dvd_q  <= dividend;
                part_q <= '0;
                cnt_q  <= CW'(WIDTH);
                dbz_q  <= 1'b0;
            end
        end else if (state == CALC) begin
            dvd_q  <= {dvd_q[WIDTH-2:0], ~borrow};
            part_q <= borrow ? shifted : trial[WIDTH:0];
            cnt_q  <= cnt_q - CW'(1);
        end
    end

    // The final partial remainder is always below the divisor, so it fits in WIDTH bits.
    assign quotient    = dvd_q;
    assign remainder   = part_q[WIDTH-1:0];
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_unit_8bit.sv
// tb_div_unit_8bit: directed and random checks of the sequential divider.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_div_unit_8bit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int n_assert = 0;
    int n_fail   = 0;

    div_unit_8bit #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one start pulse and waits for done.
    // The lat output is the number of edges after the start edge until done is seen.
    // The bsy output is the number of sampled cycles with busy high.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output int lat, output int bsy);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        bsy   = busy ? 1 : 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (busy) bsy++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    int lat, bsy, pulses, gap;
    logic [7:0] q_seen, r_seen, a, b;

    initial begin
        // Reset state
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_qr",   {16'd0, quotient, remainder}, 32'd0);
        check("rst_dbz",  {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1) 100/7: latency 8 edges, busy for 8 cycles, done lasts one cycle
        run_op(8'd100, 8'd7, lat, bsy);
        check("t1_lat",  lat, 32'd8);
        check("t1_busy", bsy, 32'd8);
        check("t1_res",  {15'd0, div_by_zero, quotient, remainder}, {15'd0, 1'b0, 8'd14, 8'd2});
        @(negedge clk);
        check("t1_done_pulse", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        check("t1_hold", {16'd0, quotient, remainder}, {16'd0, 8'd14, 8'd2});

        // 2) Boundary operands
        run_op(8'd255, 8'd1, lat, bsy);
        check("t2_255_1", {16'd0, quotient, remainder}, {16'd0, 8'd255, 8'd0});
        run_op(8'd5, 8'd10, lat, bsy);
        check("t2_5_10", {16'd0, quotient, remainder}, {16'd0, 8'd0, 8'd5});
        run_op(8'd255, 8'd255, lat, bsy);
        check("t2_255_255", {16'd0, quotient, remainder}, {16'd0, 8'd1, 8'd0});
        run_op(8'd0, 8'd5, lat, bsy);
        check("t2_0_5_lat", lat, 32'd8);
        check("t2_0_5", {16'd0, quotient, remainder}, {16'd0, 8'd0, 8'd0});

        // 3) Divide by zero: done on the start edge itself, then a normal op clears dbz
        run_op(8'd42, 8'd0, lat, bsy);
        check("t3_dbz_lat", lat, 32'd0);
        check("t3_dbz_res", {15'd0, div_by_zero, quotient, remainder}, {15'd0, 1'b1, 8'hFF, 8'd42});
        run_op(8'd9, 8'd3, lat, bsy);
        check("t3_9_3", {15'd0, div_by_zero, quotient, remainder}, {15'd0, 1'b0, 8'd3, 8'd0});

        // 4) A start during CALC is ignored; exactly one done pulse follows
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd3;
        @(negedge clk);
        start  = 1'b0;
        pulses = 0;
        q_seen = '0;
        r_seen = '0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                pulses++;
                q_seen = quotient;
                r_seen = remainder;
            end
            @(negedge clk);
        end
        check("t4_pulses", pulses, 32'd1);
        check("t4_res", {16'd0, q_seen, r_seen}, {16'd0, 8'd14, 8'd2});

        // 5) Asynchronous reset between edges in the middle of CALC
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_done", {31'd0, done}, 32'd0);
        check("t5_qr",   {16'd0, quotient, remainder}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(8'd60, 8'd8, lat, bsy);
        check("t5_60_8", {16'd0, quotient, remainder}, {16'd0, 8'd7, 8'd4});

        // 6a) Start held high back-to-back; operands change right after acceptance
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd77;
        divisor  = 8'd9;
        @(negedge clk);
        dividend = 8'd250;
        divisor  = 8'd16;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("t6_first_done", {31'd0, done}, 32'd1);
        check("t6_first", {16'd0, quotient, remainder}, {16'd0, 8'd8, 8'd5});
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!done && gap < 20);
        start = 1'b0;
        check("t6_gap", gap, 32'd10);
        check("t6_second", {16'd0, quotient, remainder}, {16'd0, 8'd15, 8'd10});

        // 6b) Random operands against a reference division
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom_range(255));
            b = (i % 50 == 0) ? 8'd0 : 8'($urandom_range(255));
            run_op(a, b, lat, bsy);
            if (b == 8'd0)
                check("rnd_dbz", {15'd0, div_by_zero, quotient, remainder}, {15'd0, 1'b1, 8'hFF, a});
            else
                check("rnd", {15'd0, div_by_zero, quotient, remainder}, {15'd0, 1'b0, a / b, a % b});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
